// File: rtl/flash_sample_reader_if.sv
// Avalon-MM read-master bundle between the sample reader and the flash slave.
interface flash_sample_reader_if;
  localparam int unsigned ADDR_W = 23;
  localparam int unsigned DATA_W = 32;

  logic              read;
  logic [ADDR_W-1:0] address;
  logic [3:0]        byteenable;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output read, address, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  read, address, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/flash_sample_reader.sv
// Delivers one 8-bit sample per sample_tick, fetching 32-bit flash words on demand
// and unpacking two samples per word, forward or backward through the song.
module flash_sample_reader #(
  parameter logic [22:0] MAX_ADDR = 23'h7FFFF
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  sample_tick,
  input  logic                  direction,
  input  logic                  pause,
  input  logic                  restart,
  flash_sample_reader_if.master flash_mem,
  output logic [7:0]            audio_data,
  output logic [7:0]            missed_ticks
);

  localparam int unsigned ADDR_W   = 23;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned SAMPLE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_DATA,
    OUTPUT
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr;
  logic                half;
  logic                pending;
  logic                loaded;
  logic                discard;
  logic                dir_reg;
  logic [DATA_W-1:0]   word_reg;

  logic                tick_c;
  logic                go_c;
  logic [ADDR_W-1:0]   step_addr_c;
  logic [ADDR_W-1:0]   start_now_c;
  logic [ADDR_W-1:0]   start_latched_c;
  logic [SAMPLE_W-1:0] sample_c;
  logic                unused_bytes_c;

  assign flash_mem.address    = addr;
  assign flash_mem.byteenable = 4'hF;

  assign tick_c = sample_tick & ~pause;
  assign go_c   = ~pause & (sample_tick | pending);

  // Start points: the live direction for an immediate restart, the latched one
  // for a restart deferred until an in-flight request is accepted.
  assign start_now_c     = direction ? MAX_ADDR : ADDR_W'(0);
  assign start_latched_c = dir_reg   ? MAX_ADDR : ADDR_W'(0);

  // Middle and low bytes of each word carry no sample.
  assign unused_bytes_c = ^{word_reg[23:16], word_reg[7:0]};

  always_comb begin
    step_addr_c = addr;
    if (dir_reg) begin
      step_addr_c = (addr == ADDR_W'(0)) ? MAX_ADDR : addr - ADDR_W'(1);
    end else begin
      step_addr_c = (addr == MAX_ADDR) ? ADDR_W'(0) : addr + ADDR_W'(1);
    end
  end

  always_comb begin
    sample_c = word_reg[15:8];
    if (dir_reg ^ half) begin
      sample_c = word_reg[31:24];
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      addr           <= '0;
      half           <= 1'b0;
      pending        <= 1'b0;
      loaded         <= 1'b0;
      discard        <= 1'b0;
      dir_reg        <= 1'b0;
      word_reg       <= '0;
      flash_mem.read <= 1'b0;
      audio_data     <= '0;
      missed_ticks   <= '0;
    end else begin
      // Ticks that land while busy: the first is remembered, later ones dropped.
      if (state != IDLE && !restart && tick_c) begin
        if (pending) begin
          if (missed_ticks != 8'hFF) begin
            missed_ticks <= missed_ticks + 8'd1;
          end
        end else begin
          pending <= 1'b1;
        end
      end
      if (pause) begin
        pending <= 1'b0;
      end

      if (restart) begin
        if (state != REQ) begin
          addr <= start_now_c;
        end
        half    <= 1'b0;
        pending <= 1'b0;
        loaded  <= 1'b0;
        dir_reg <= direction;
        if (state == REQ || state == WAIT_DATA) begin
          discard <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (!restart && go_c) begin
            pending <= pending & sample_tick;
            if (half || loaded) begin
              state <= OUTPUT;
            end else begin
              dir_reg        <= direction;
              flash_mem.read <= 1'b1;
              state          <= REQ;
            end
          end
        end

        REQ: begin
          // Address stays put while read is high; a restart lands at acceptance.
          if (!flash_mem.waitrequest) begin
            flash_mem.read <= 1'b0;
            state          <= WAIT_DATA;
            if (restart) begin
              addr <= start_now_c;
            end else if (discard) begin
              addr <= start_latched_c;
            end
          end
        end

        WAIT_DATA: begin
          if (flash_mem.readdatavalid) begin
            if (discard || restart) begin
              discard <= 1'b0;
              state   <= IDLE;
            end else begin
              word_reg <= flash_mem.readdata;
              if (pause) begin
                loaded <= 1'b1;
                state  <= IDLE;
              end else begin
                state <= OUTPUT;
              end
            end
          end
        end

        OUTPUT: begin
          if (restart) begin
            state <= IDLE;
          end else if (pause) begin
            loaded <= 1'b1;
            state  <= IDLE;
          end else begin
            audio_data <= sample_c;
            half       <= ~half;
            loaded     <= 1'b0;
            if (half) begin
              addr <= step_addr_c;
            end
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_sample_reader.sv
// Directed and randomized checks of flash_sample_reader against an in-bench
// playback model and an Avalon flash slave model.
module tb_flash_sample_reader;

  localparam logic [22:0] MAX_A = 23'h7FFFF;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       dir = 1'b0;
  logic       pause = 1'b0;
  logic       restart = 1'b0;
  logic [7:0] audio;
  logic [7:0] missed;

  flash_sample_reader_if bus();

  flash_sample_reader #(.MAX_ADDR(MAX_A)) dut (
    .CLOCK_50     (clk),
    .reset        (rst),
    .sample_tick  (tick),
    .direction    (dir),
    .pause        (pause),
    .restart      (restart),
    .flash_mem    (bus),
    .audio_data   (audio),
    .missed_ticks (missed)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Slave configuration and bookkeeping
  int          wr_fixed = -1;
  int          lat_fixed = -1;
  bit          hold_valid = 1'b0;
  bit          new_req = 1'b1;
  int          wr_left = 0;
  int          due_q[$];
  logic [31:0] data_q[$];
  logic [22:0] last_addr = '0;
  int          acc_count = 0;
  logic [31:0] mem_ovr [int];

  // Playback model
  bit          model_on = 1'b0;
  logic [22:0] pos_addr = '0;
  logic        pos_half = 1'b0;
  logic        pos_dir = 1'b0;
  logic [22:0] fetch_addr = '0;
  logic [7:0]  fetch_sample = '0;
  int          exp_eff[$];
  logic [7:0]  exp_val[$];
  logic [7:0]  exp_audio = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [22:0] a);
    if (mem_ovr.exists(int'(a))) return mem_ovr[int'(a)];
    return (32'(a) * 32'h9E3779B1) ^ 32'h5BD1E995;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) step();
  endtask

  task automatic do_tick();
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic pulse_restart();
    step();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  // Applies the playback rules for one serviced tick and schedules the expected output.
  task automatic model_tick();
    logic [31:0] w;
    logic [7:0]  s;
    if (!pos_half) pos_dir = dir;
    w = mem_word(pos_addr);
    if (!pos_dir) s = pos_half ? w[31:24] : w[15:8];
    else          s = pos_half ? w[15:8]  : w[31:24];
    step();
    if (!pos_half) begin
      fetch_addr   = pos_addr;
      fetch_sample = s;
    end else begin
      exp_eff.push_back(cyc + 2);
      exp_val.push_back(s);
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("read_after_tick", 32'(bus.read), pos_half ? 32'd0 : 32'd1);
    if (pos_half) begin
      if (!pos_dir) pos_addr = (pos_addr == MAX_A) ? 23'd0 : pos_addr + 23'd1;
      else          pos_addr = (pos_addr == 23'd0) ? MAX_A : pos_addr - 23'd1;
    end
    pos_half = ~pos_half;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Flash slave: drives on the falling edge so the DUT samples stable values.
  initial begin
    bus.waitrequest   = 1'b1;
    bus.readdata      = '0;
    bus.readdatavalid = 1'b0;
    forever begin
      @(negedge clk);
      bus.readdatavalid = 1'b0;
      bus.readdata      = $urandom;
      if (!hold_valid && due_q.size() > 0 && due_q[0] <= cyc) begin
        bus.readdatavalid = 1'b1;
        bus.readdata      = data_q[0];
        void'(due_q.pop_front());
        void'(data_q.pop_front());
        if (model_on) begin
          exp_eff.push_back(cyc + 2);
          exp_val.push_back(fetch_sample);
        end
      end
      if (bus.read) begin
        if (new_req) begin
          wr_left = (wr_fixed >= 0) ? wr_fixed : int'($urandom_range(0, 3));
          new_req = 1'b0;
        end
        if (wr_left > 0) begin
          bus.waitrequest = 1'b1;
          wr_left--;
        end else begin
          bus.waitrequest = 1'b0;
          new_req   = 1'b1;
          last_addr = bus.address;
          acc_count++;
          due_q.push_back(cyc + ((lat_fixed >= 0) ? lat_fixed : int'($urandom_range(1, 4))));
          data_q.push_back(mem_word(bus.address));
          if (model_on) check("read_addr", 32'(bus.address), 32'(fetch_addr));
        end
      end else begin
        bus.waitrequest = 1'(($urandom_range(0, 1)));
      end
    end
  end

  // Per-cycle comparison against the model while it is active.
  initial forever begin
    @(posedge clk);
    #1;
    if (model_on) begin
      while (exp_eff.size() > 0 && exp_eff[0] <= cyc) begin
        exp_audio = exp_val.pop_front();
        void'(exp_eff.pop_front());
      end
      check("audio_data", 32'(audio), 32'(exp_audio));
      check("missed_ticks", 32'(missed), 32'd0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int acc0;

    wait_cycles(3);
    check("reset_audio", 32'(audio), 32'd0);
    check("reset_missed", 32'(missed), 32'd0);
    check("reset_read", 32'(bus.read), 32'd0);
    check("reset_addr", 32'(bus.address), 32'd0);
    check("byteenable", 32'(bus.byteenable), 32'hF);
    step();
    rst = 1'b0;
    mem_ovr[0] = 32'hA1B2C3D4;
    mem_ovr[int'(MAX_A)] = 32'h11223344;
    wr_fixed  = 3;
    lat_fixed = 2;

    // Forward playback
    dir = 1'b0;
    do_tick(); wait_cycles(50);
    check("fwd_first", 32'(audio), 32'hC3);
    check("fwd_addr0", 32'(last_addr), 32'd0);
    do_tick(); wait_cycles(50);
    check("fwd_second", 32'(audio), 32'hA1);
    check("fwd_one_fetch", 32'(acc_count), 32'd1);
    do_tick(); wait_cycles(50);
    check("fwd_addr1", 32'(last_addr), 32'd1);
    w = mem_word(23'd1);
    check("fwd_third", 32'(audio), 32'(w[15:8]));

    // Backward playback
    dir = 1'b1;
    pulse_restart(); wait_cycles(5);
    do_tick(); wait_cycles(50);
    check("bwd_addr", 32'(last_addr), 32'h7FFFF);
    check("bwd_first", 32'(audio), 32'h11);
    do_tick(); wait_cycles(50);
    check("bwd_second", 32'(audio), 32'h33);
    do_tick(); wait_cycles(50);
    check("bwd_next_addr", 32'(last_addr), 32'h7FFFE);

    // Forward wrap from the last word
    dir = 1'b1;
    pulse_restart(); wait_cycles(5);
    dir = 1'b0;
    do_tick(); wait_cycles(50);
    check("wrap_addr", 32'(last_addr), 32'h7FFFF);
    check("wrap_first", 32'(audio), 32'h33);
    do_tick(); wait_cycles(50);
    check("wrap_second", 32'(audio), 32'h11);
    do_tick(); wait_cycles(50);
    check("wrap_next_addr", 32'(last_addr), 32'd0);
    check("wrap_next_sample", 32'(audio), 32'hC3);

    // Overrun with readdatavalid held off
    pulse_restart(); wait_cycles(5);
    acc0 = acc_count;
    hold_valid = 1'b1;
    do_tick(); wait_cycles(8);
    do_tick(); wait_cycles(8);
    do_tick(); wait_cycles(75);
    check("overrun_missed_held", 32'(missed), 32'd1);
    hold_valid = 1'b0;
    wait_cycles(20);
    check("overrun_audio", 32'(audio), 32'hA1);
    check("overrun_missed", 32'(missed), 32'd1);
    check("overrun_fetches", 32'(acc_count), 32'(acc0 + 1));

    // Restart while waiting for data
    hold_valid = 1'b1;
    do_tick(); wait_cycles(8);
    pulse_restart(); wait_cycles(5);
    hold_valid = 1'b0;
    wait_cycles(20);
    check("restart_audio_hold", 32'(audio), 32'hA1);
    do_tick(); wait_cycles(50);
    check("restart_next_addr", 32'(last_addr), 32'd0);
    check("restart_next_sample", 32'(audio), 32'hC3);

    // Reset during a stalled request
    dir = 1'b1;
    pulse_restart(); wait_cycles(5);
    wr_fixed = 20;
    do_tick(); wait_cycles(3);
    check("req_read_high", 32'(bus.read), 32'd1);
    check("req_addr", 32'(bus.address), 32'h7FFFF);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_read", 32'(bus.read), 32'd0);
    check("async_rst_addr", 32'(bus.address), 32'd0);
    check("async_rst_audio", 32'(audio), 32'd0);
    check("async_rst_missed", 32'(missed), 32'd0);
    new_req = 1'b1;
    wr_left = 0;
    due_q.delete();
    data_q.delete();
    wr_fixed  = -1;
    lat_fixed = -1;
    wait_cycles(3);
    dir = 1'b0;
    rst = 1'b0;
    pos_addr  = '0;
    pos_half  = 1'b0;
    pos_dir   = 1'b0;
    exp_audio = '0;
    exp_eff.delete();
    exp_val.delete();
    model_on = 1'b1;

    // Randomized playback with direction changes and paused ticks
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        step();
        dir = ~dir;
      end
      if ($urandom_range(0, 5) == 0) begin
        step();
        pause = 1'b1;
        wait_cycles(2);
        do_tick();
        wait_cycles(int'($urandom_range(2, 6)));
        pause = 1'b0;
      end
      model_tick();
      wait_cycles(int'($urandom_range(14, 24)));
    end
    wait_cycles(30);
    model_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flash_sample_reader.md
# flash_sample_reader

Consumer end of the sample-rate strobe path. Each single-cycle `sample_tick` pulse arrives in the `CLOCK_50` domain from the clock synchronizer/edge detector. On each pulse the block delivers the next 8-bit audio sample. It fetches 32-bit words from the flash Avalon-MM slave as needed and unpacks two samples per word, forward or backward through the song. It sits between the synchronizer and the audio DAC interface.

## Interface
- `MAX_ADDR`, default 23'h7FFFF: last word address of the song; the address wraps at this boundary.
- `CLOCK_50`  in  1: sole clock; all logic is on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `sample_tick`  in  1: one-cycle strobe from the synchronizer, one per sample period.
- `direction`  in  1: 0 = forward (address increments), 1 = backward (address decrements).
- `pause`  in  1: while 1, ticks are ignored and `audio_data` holds.
- `restart`  in  1: one-cycle pulse; playback restarts from the start point for the current direction.
- `flash_mem_read`  out  1: Avalon read request.
- `flash_mem_address`  out  23: word address.
- `flash_mem_byteenable`  out  4: constant 4'hF.
- `flash_mem_waitrequest`  in  1: slave stall.
- `flash_mem_readdata`  in  32: read data.
- `flash_mem_readdatavalid`  in  1: read data qualifier.
- `audio_data`  out  8: current sample, registered.
- `missed_ticks`  out  8: count of dropped ticks; saturates at 8'hFF.

## Operation
- FSM states: IDLE, REQ, WAIT_DATA, OUTPUT.
- **IDLE:**
  - A tick (or pending tick) with `half`=0 goes to REQ.
  - A tick with `half`=1 goes to OUTPUT.
- **REQ:**
  - Assert `flash_mem_read` with a stable address.
  - When `flash_mem_waitrequest`=0, the request is accepted; deassert read and go to WAIT_DATA.
- **WAIT_DATA:**
  - On `flash_mem_readdatavalid`=1, latch `readdata` into `word_reg` and go to OUTPUT.
- **OUTPUT** (one cycle), driving `audio_data`:
  - Forward, `half`=0: `word_reg[15:8]`.
  - Forward, `half`=1: `word_reg[31:24]`.
  - Backward, `half`=0: `word_reg[31:24]`.
  - Backward, `half`=1: `word_reg[15:8]`.
  - Then toggle `half`. When `half` returns to 0, step the address (+1 forward, -1 backward) and return to IDLE.
- **Address wrap:**
  - Forward past `MAX_ADDR` goes to 0.
  - Backward below 0 goes to `MAX_ADDR`.
- **Direction:** sampled only when `half` is 0 in IDLE. A change in mid-word takes effect at the next word fetch.
- **Tick while not in IDLE:** sets the `pending` flag. If `pending` is already set, the tick is dropped and `missed_ticks` increments.
- **Pause:** ticks are neither acted on nor counted, and `pending` is cleared. An in-flight read still completes and is latched, but OUTPUT is held off until the next unpaused tick.
- **Restart:**
  - Sets the address to 0 (forward) or `MAX_ADDR` (backward), `half`=0, `pending`=0.
  - If issued in REQ or WAIT_DATA, the outstanding read completes: REQ keeps `flash_mem_read` asserted until accepted, then the returned data is discarded and the FSM goes to IDLE. It does not go to OUTPUT.
  - `audio_data` holds its value.
- **Simultaneous `restart` and tick:** restart wins; the tick is dropped and not counted.
- **Reset values:**
  - `flash_mem_read`=0, `flash_mem_address`=0, `audio_data`=0, `missed_ticks`=0.
  - State IDLE, `half`=0, `pending`=0, `word_reg`=0.
  - Reset mid-transaction abandons the read immediately.

## Timing
- **Tick with `half`=0**, tick in cycle T:
  - `flash_mem_read`=1 from T+1.
  - Request accepted in the first cycle of the read with `waitrequest`=0.
  - `readdatavalid` observed in cycle V; `audio_data` updates at the V+1 edge (one cycle after valid).
- **Tick with `half`=1**, tick in cycle T: `audio_data` updates at the T+2 edge (IDLE→OUTPUT, then register).
- **Pending tick:** consumed in the first IDLE cycle, with the same timing as a fresh tick.
- **Address:** changes only at the OUTPUT-to-IDLE transition or on restart, never while `flash_mem_read`=1.
- **Throughput requirement:** read latency is at most (tick period − 4) cycles, so no ticks are missed.

## Test plan
- **Forward playback:** reset, `direction`=0, model returns 32'hA1B2C3D4 at address 0 with 3 cycles of waitrequest and 2 cycles of valid latency; issue two ticks 50 cycles apart → `audio_data`=8'hC3, then 8'hA1; next tick reads address 1.
- **Backward playback:** restart with `direction`=1; model returns 32'h11223344 at 23'h7FFFF → read address 23'h7FFFF, `audio_data`=8'h11, then 8'h33; next fetch at 23'h7FFFE.
- **Wrap:** preload the address to `MAX_ADDR` forward, consume both halves → next read address 0.
- **Overrun:** hold readdatavalid off for 100 cycles while issuing 3 ticks 10 cycles apart → one pending tick serviced, `missed_ticks`=1.
- **Restart mid-read:** pulse restart in WAIT_DATA → returned data discarded, `audio_data` unchanged, next read at address 0.
- **Reset mid-REQ:** assert reset while `flash_mem_read`=1 → `flash_mem_read`=0 and all outputs 0 asynchronously.
